// File: rtl/param_rf_pkg.sv
// ---------------------------------------------------------------------------
// param_rf_pkg
//
// Purpose:
//   Shared types and helpers for the parametrised software/hardware register
//   file (param_rf).
//
// Contents:
//   access_mode_t  - per-register software access behaviour
//   WORD_SHIFT     - byte-to-word address shift (registers are 8-byte words)
//   mode_of()      - resolves a register's mode from its three mask bits
// ---------------------------------------------------------------------------
package param_rf_pkg;

    // Software-visible behaviour of a single register.
    //   MODE_RW  : plain read/write
    //   MODE_RO  : software writes are ignored
    //   MODE_W1C : software write clears the bits written as 1
    //   MODE_RC  : a software read clears the register after sampling
    typedef enum logic [1:0] {
        MODE_RW  = 2'd0,
        MODE_RO  = 2'd1,
        MODE_W1C = 2'd2,
        MODE_RC  = 2'd3
    } access_mode_t;

    // Registers are 64-bit words, so the low three byte-address bits are
    // not carried on the port.
    localparam int WORD_SHIFT = 3;

    // Resolve the access mode of one register from its bits in the three
    // masks. A register flagged in several masks takes the most restrictive
    // meaning first: read-only beats write-1-to-clear, which beats
    // clear-on-read.
    function automatic access_mode_t mode_of(input logic ro_bit,
                                             input logic w1c_bit,
                                             input logic rc_bit);
        access_mode_t mode;
        if (ro_bit) begin
            mode = MODE_RO;
        end else if (w1c_bit) begin
            mode = MODE_W1C;
        end else if (rc_bit) begin
            mode = MODE_RC;
        end else begin
            mode = MODE_RW;
        end
        return mode;
    endfunction

endpackage

// File: rtl/param_rf_cell.sv
// ---------------------------------------------------------------------------
// param_rf_cell
//
// Purpose:
//   One register of the register file, with its software access mode,
//   hardware-over-software update priority and reset value.
//
// Ports:
//   clk         in   clock
//   res         in   asynchronous active-high reset
//   sw_write    in   validated software write targeting this register
//   sw_read     in   validated software read targeting this register
//   write_data  in   software write data
//   hw_wen      in   hardware write enable (wins over software)
//   hw_next     in   hardware next value
//   q           out  current register contents
//   sw_written  out  one-cycle pulse after an effective software write
// ---------------------------------------------------------------------------
module param_rf_cell
    import param_rf_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 64,
    parameter access_mode_t          MODE        = MODE_RW,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  sw_write,
    input  logic                  sw_read,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  hw_wen,
    input  logic [DATA_WIDTH-1:0] hw_next,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  sw_written
);

    // A software write counts as effective when it reaches a writable
    // register and hardware is not overriding it in the same cycle. A
    // write-1-to-clear with all-zero data is still effective even though
    // the contents do not change.
    logic write_effective;

    assign write_effective = sw_write && !hw_wen && (MODE != MODE_RO);

    // Register update. Hardware has absolute priority; otherwise a software
    // write is applied according to the mode, and a clear-on-read register
    // is zeroed by a read. The top level never presents a write and a read
    // together, so the write/read ordering below carries no meaning.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            q <= RESET_VALUE;
        end else if (hw_wen) begin
            q <= hw_next;
        end else if (sw_write) begin
            case (MODE)
                MODE_RW:  q <= write_data;
                MODE_W1C: q <= q & ~write_data;
                MODE_RC:  q <= write_data;
                default:  q <= q;
            endcase
        end else if (sw_read && (MODE == MODE_RC)) begin
            q <= '0;
        end
    end

    // Completion pulse for an effective software write, lasting one cycle.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sw_written <= 1'b0;
        end else begin
            sw_written <= write_effective;
        end
    end

endmodule

// File: rtl/param_rf.sv
// ---------------------------------------------------------------------------
// param_rf
//
// Purpose:
//   Parametrised register file with NUM_REGS registers of DATA_WIDTH bits.
//   Software reaches the registers through one word-addressed port with a
//   registered completion/error handshake; hardware can load every register
//   directly and always wins over software in the same cycle.
//
// Ports:
//   clk              in   clock
//   res              in   asynchronous active-high reset
//   address          in   word address (byte-address bits [ADDR_WIDTH-1:3])
//   read_en          in   software read strobe
//   write_en         in   software write strobe
//   write_data       in   software write data
//   read_data        out  registered read data
//   access_complete  out  one-cycle pulse for a completed access
//   invalid_address  out  one-cycle pulse for a rejected access
//   hw_next          in   hardware next values, register i at slice i
//   hw_wen           in   hardware write enables, one per register
//   reg_q            out  current register contents, register i at slice i
//   sw_written       out  one-cycle pulse per register after an effective
//                         software write
// ---------------------------------------------------------------------------
module param_rf
    import param_rf_pkg::*;
#(
    parameter int                             DATA_WIDTH  = 64,
    parameter int                             NUM_REGS    = 4,
    parameter int                             ADDR_WIDTH  = 6,
    parameter logic [NUM_REGS-1:0]            RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]            W1C_MASK    = '0,
    parameter logic [NUM_REGS-1:0]            RC_MASK     = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             res,
    input  logic [ADDR_WIDTH-WORD_SHIFT-1:0] address,
    input  logic                             read_en,
    input  logic                             write_en,
    input  logic [DATA_WIDTH-1:0]            write_data,
    output logic [DATA_WIDTH-1:0]            read_data,
    output logic                             access_complete,
    output logic                             invalid_address,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_next,
    input  logic [NUM_REGS-1:0]              hw_wen,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_q,
    output logic [NUM_REGS-1:0]              sw_written
);

    logic [31:0]           addr_index;
    logic                  addr_in_range;
    logic                  request;
    logic                  access_ok;
    logic                  access_bad;
    logic [NUM_REGS-1:0]   addr_sel;
    logic [NUM_REGS-1:0]   cell_write;
    logic [NUM_REGS-1:0]   cell_read;
    logic [DATA_WIDTH-1:0] cell_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] read_word;

    // Request classification. A strobe on an out-of-range address, or both
    // strobes at once, is rejected with the error pulse and has no side
    // effects. Everything else is a valid access.
    assign addr_index    = 32'(address);
    assign addr_in_range = (addr_index < NUM_REGS);
    assign request       = read_en || write_en;
    assign access_ok     = request && !(read_en && write_en) && addr_in_range;
    assign access_bad    = request && !access_ok;

    // One-hot address decode, qualified into per-register write and read
    // strobes so that each cell only sees accesses it must act on.
    always_comb begin
        addr_sel   = '0;
        cell_write = '0;
        cell_read  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_sel[i]   = (addr_index == i);
            cell_write[i] = access_ok && write_en && addr_sel[i];
            cell_read[i]  = access_ok && read_en && addr_sel[i];
        end
    end

    // Read mux on the pre-edge register contents, so a clear-on-read or a
    // simultaneous hardware load still returns the value held before the
    // access.
    always_comb begin
        read_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_sel[i]) begin
                read_word = cell_q[i];
            end
        end
    end

    // One cell per register; the mode of each is fixed at elaboration from
    // the mask bits, and reg_q is the cells' outputs without extra delay.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
        param_rf_cell #(
            .DATA_WIDTH  (DATA_WIDTH),
            .MODE        (mode_of(RO_MASK[g], W1C_MASK[g], RC_MASK[g])),
            .RESET_VALUE (RESET_VALUE[g*DATA_WIDTH +: DATA_WIDTH])
        ) u_cell (
            .clk         (clk),
            .res         (res),
            .sw_write    (cell_write[g]),
            .sw_read     (cell_read[g]),
            .write_data  (write_data),
            .hw_wen      (hw_wen[g]),
            .hw_next     (hw_next[g*DATA_WIDTH +: DATA_WIDTH]),
            .q           (cell_q[g]),
            .sw_written  (sw_written[g])
        );

        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = cell_q[g];
    end

    // Handshake registers. Every request produces exactly one of the two
    // pulses one cycle later. read_data is only refreshed by a completed
    // read (with the register value) or a rejected access (with zero), and
    // otherwise holds, so writes and idle cycles leave it alone.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            access_complete <= 1'b0;
            invalid_address <= 1'b0;
            read_data       <= '0;
        end else begin
            access_complete <= access_ok;
            invalid_address <= access_bad;
            if (access_ok && read_en) begin
                read_data <= read_word;
            end else if (access_bad) begin
                read_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_param_rf.sv
// ---------------------------------------------------------------------------
// tb_param_rf
//
// Purpose:
//   Self-checking bench for param_rf with four 64-bit registers:
//   reg 0 RW, reg 1 W1C, reg 2 RC, reg 3 RO (with a non-zero reset value).
//   A behavioural model of the register file predicts every output.
// ---------------------------------------------------------------------------
module tb_param_rf;

    localparam int           DW  = 64;
    localparam int           NR  = 4;
    localparam int           AW  = 6;
    localparam logic [3:0]   RO  = 4'b1000;
    localparam logic [3:0]   W1C = 4'b0010;
    localparam logic [3:0]   RC  = 4'b0100;
    localparam logic [255:0] RV  = {64'hDEAD_BEEF_0000_0003,
                                    64'h0000_0000_0000_0002,
                                    64'h0000_0000_0000_0001,
                                    64'h0000_0000_0000_0000};

    logic          clk;
    logic          res;
    logic [2:0]    address;
    logic          read_en;
    logic          write_en;
    logic [63:0]   write_data;
    logic [63:0]   read_data;
    logic          access_complete;
    logic          invalid_address;
    logic [255:0]  hw_next;
    logic [3:0]    hw_wen;
    logic [255:0]  reg_q;
    logic [3:0]    sw_written;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: register contents and the expected outputs.
    logic [63:0] m_reg [NR];
    logic [63:0] exp_rd;
    logic        exp_ac;
    logic        exp_inv;
    logic [3:0]  exp_sw;

    param_rf #(
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NR),
        .ADDR_WIDTH  (AW),
        .RO_MASK     (RO),
        .W1C_MASK    (W1C),
        .RC_MASK     (RC),
        .RESET_VALUE (RV)
    ) dut (
        .clk             (clk),
        .res             (res),
        .address         (address),
        .read_en         (read_en),
        .write_en        (write_en),
        .write_data      (write_data),
        .read_data       (read_data),
        .access_complete (access_complete),
        .invalid_address (invalid_address),
        .hw_next         (hw_next),
        .hw_wen          (hw_wen),
        .reg_q           (reg_q),
        .sw_written      (sw_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] model_q();
        return {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) m_reg[i] = RV[i*64 +: 64];
        exp_rd  = '0;
        exp_ac  = 1'b0;
        exp_inv = 1'b0;
        exp_sw  = '0;
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, ".access_complete"}, 256'(access_complete), 256'(exp_ac));
        check({tag, ".invalid_address"}, 256'(invalid_address), 256'(exp_inv));
        check({tag, ".read_data"},       256'(read_data),       256'(exp_rd));
        check({tag, ".sw_written"},      256'(sw_written),      256'(exp_sw));
        check({tag, ".reg_q"},           reg_q,                 model_q());
    endtask

    // One clock of stimulus: inputs change on the falling edge, the model
    // works out the result of the coming rising edge from the access rules,
    // and outputs are compared just after that rising edge.
    task automatic applyStimulus(input string tag, input logic rd,
                                 input logic wr, input logic [2:0] addr,
                                 input logic [63:0] wd, input logic [3:0] hwe,
                                 input logic [255:0] hwn);
        logic        valid;
        logic [63:0] nxt [NR];
        @(negedge clk);
        read_en    = rd;
        write_en   = wr;
        address    = addr;
        write_data = wd;
        hw_wen     = hwe;
        hw_next    = hwn;

        valid   = (rd || wr) && !(rd && wr) && (int'(addr) < NR);
        exp_ac  = valid;
        exp_inv = (rd || wr) && !valid;
        exp_sw  = '0;
        if (valid && rd) exp_rd = m_reg[addr[1:0]];
        else if (exp_inv) exp_rd = '0;

        for (int i = 0; i < NR; i++) begin
            nxt[i] = m_reg[i];
            if (hwe[i]) begin
                nxt[i] = hwn[i*64 +: 64];
            end else if (valid && wr && int'(addr) == i) begin
                if (RO[i]) begin
                    nxt[i] = m_reg[i];
                end else if (W1C[i]) begin
                    nxt[i] = m_reg[i] & ~wd;
                    exp_sw[i] = 1'b1;
                end else begin
                    nxt[i] = wd;
                    exp_sw[i] = 1'b1;
                end
            end else if (valid && rd && int'(addr) == i && RC[i]) begin
                nxt[i] = '0;
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) m_reg[i] = nxt[i];
        checkOutput(tag);
    endtask

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] junk;
        int           sel;
        logic [3:0]   hwe;

        res        = 1'b1;
        address    = '0;
        read_en    = 1'b0;
        write_en   = 1'b0;
        write_data = '0;
        hw_wen     = '0;
        hw_next    = '0;
        modelReset();

        // Reset state, sampled on a falling edge while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        res = 1'b0;

        // Software write to the RW register.
        applyStimulus("rw_write", 1'b0, 1'b1, 3'd0, 64'h555A_AA55_5AAA_555A, 4'b0000, '0);
        check("rw_write.const", 256'(reg_q[63:0]), 256'(64'h555A_AA55_5AAA_555A));
        check("rw_write.swpulse", 256'(sw_written[0]), 256'(1'b1));

        // Hardware load beats a same-cycle software write.
        applyStimulus("hw_wins", 1'b0, 1'b1, 3'd0, 64'hFFFF, 4'b0001, '0);
        check("hw_wins.const", 256'(reg_q[63:0]), 256'd0);

        // Write-1-to-clear on register 1.
        applyStimulus("w1c_load", 1'b0, 1'b0, 3'd0, '0, 4'b0010, {128'd0, 64'hF0, 64'd0});
        applyStimulus("w1c_write", 1'b0, 1'b1, 3'd1, 64'h30, 4'b0000, '0);
        check("w1c.const", 256'(reg_q[127:64]), 256'(64'hC0));
        applyStimulus("w1c_zero", 1'b0, 1'b1, 3'd1, 64'h0, 4'b0000, '0);

        // Clear-on-read on register 2.
        applyStimulus("rc_load", 1'b0, 1'b0, 3'd0, '0, 4'b0100, {64'd0, 64'h1234, 128'd0});
        applyStimulus("rc_read1", 1'b1, 1'b0, 3'd2, '0, 4'b0000, '0);
        check("rc_read1.const", 256'(read_data), 256'(64'h1234));
        applyStimulus("rc_read2", 1'b1, 1'b0, 3'd2, '0, 4'b0000, '0);

        // Rejected accesses: out-of-range address, then both strobes.
        applyStimulus("rd_w1c", 1'b1, 1'b0, 3'd1, '0, 4'b0000, '0);
        applyStimulus("bad_addr", 1'b1, 1'b0, 3'd4, '0, 4'b0000, '0);
        applyStimulus("both_strobes", 1'b1, 1'b1, 3'd0, 64'hABCD, 4'b0000, '0);
        applyStimulus("bad_write", 1'b0, 1'b1, 3'd7, 64'h1, 4'b0000, '0);

        // Read-only register ignores writes but completes.
        applyStimulus("ro_write", 1'b0, 1'b1, 3'd3, 64'h1111, 4'b0000, '0);
        applyStimulus("ro_read", 1'b1, 1'b0, 3'd3, '0, 4'b0000, '0);

        // Hardware load during a clear-on-read read: read sees old value.
        applyStimulus("rc_load2", 1'b0, 1'b0, 3'd0, '0, 4'b0100, {64'd0, 64'h77, 128'd0});
        applyStimulus("rc_hw_read", 1'b1, 1'b0, 3'd2, '0, 4'b0100, {64'd0, 64'h99, 128'd0});

        // Randomized traffic, including held strobes and hardware loads.
        for (int n = 0; n < 300; n++) begin
            sel  = $urandom_range(0, 9);
            junk = rand256();
            hwe  = '0;
            for (int i = 0; i < NR; i++) hwe[i] = ($urandom_range(0, 7) == 0);
            applyStimulus("random", sel <= 3 || sel == 8, (sel >= 4 && sel <= 8),
                          3'($urandom_range(0, 7)), {$urandom, $urandom}, hwe, junk);
        end

        // Asynchronous reset in the middle of a write access.
        applyStimulus("pre_w", 1'b0, 1'b1, 3'd0, 64'h0123_4567_89AB_CDEF, 4'b0000, '0);
        applyStimulus("pre_r", 1'b1, 1'b0, 3'd0, '0, 4'b0000, '0);
        applyStimulus("pre_w2", 1'b0, 1'b1, 3'd0, 64'h0F0F, 4'b0000, '0);
        @(negedge clk);
        write_en   = 1'b1;
        address    = 3'd0;
        write_data = 64'hFEED;
        #2;
        res = 1'b1;
        #1;
        modelReset();
        checkOutput("async_reset");
        @(posedge clk);
        #1;
        checkOutput("reset_hold");
        @(negedge clk);
        res      = 1'b0;
        write_en = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_rf.md
Name: param_rf

Overview:
- Parametrised successor to the single-register software/hardware register file.
- Provides NUM_REGS registers of DATA_WIDTH bits behind one word-addressed software port with a registered access handshake.
- Every register also has a hardware update port.
- Per-register access modes: read/write, read-only, write-1-to-clear, clear-on-read.
- Sits between the host bus bridge and block-level control/status logic.

Parameters:
- DATA_WIDTH, 64, width of every register and of the software data bus.
- NUM_REGS, 4, number of registers; valid word addresses are 0..NUM_REGS-1.
- ADDR_WIDTH, 6, byte-address width; the port carries word-address bits [ADDR_WIDTH-1:3].
- RO_MASK, 0, bit i=1: register i ignores software writes.
- W1C_MASK, 0, bit i=1: a software write clears the bits of register i where write_data is 1.
- RC_MASK, 0, bit i=1: a valid software read of register i clears it after sampling.
- RESET_VALUE, 0, NUM_REGS*DATA_WIDTH packed reset value per register.

Ports:
- clk  in  1  clock
- res  in  1  reset
- address  in  ADDR_WIDTH-3  word address, bits [ADDR_WIDTH-1:3]
- read_en  in  1  software read strobe
- write_en  in  1  software write strobe
- write_data  in  DATA_WIDTH  software write data
- read_data  out  DATA_WIDTH  registered read data
- access_complete  out  1  one-cycle completion pulse
- invalid_address  out  1  one-cycle error pulse
- hw_next  in  NUM_REGS*DATA_WIDTH  hardware next values, register i at slice i
- hw_wen  in  NUM_REGS  hardware write enables
- reg_q  out  NUM_REGS*DATA_WIDTH  current register contents
- sw_written  out  NUM_REGS  one-cycle pulse after an effective software write to register i

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values while res is high:
  - registers = RESET_VALUE
  - read_data = 0
  - access_complete = 0
  - invalid_address = 0
  - sw_written = 0
- Reset asserted mid-access aborts the access; no completion is issued.
- Handshake:
  - A request is read_en or write_en sampled high on a clk rising edge.
  - Exactly one of access_complete or invalid_address pulses high for one cycle after that edge (latency 1).
  - Strobes may be held on consecutive cycles; each cycle is a new access.
- Address check:
  - An address >= NUM_REGS gives invalid_address=1 and access_complete=0.
  - Nothing is written; read_data is driven 0.
- Both read_en and write_en high in the same cycle:
  - Treated as invalid: invalid_address=1, no state change, read_data=0.
- Software write to a valid address, applied at the same edge:
  - RW register: reg <= write_data.
  - RO register: no change, access_complete still 1, sw_written stays 0.
  - W1C register: reg <= reg & ~write_data.
- Software read of a valid address:
  - read_data <= reg value before the edge.
  - RC register: cleared to 0 at the same edge.
- read_data holds its value until the next completed read or invalid access. Writes do not change read_data.
- Priority: hw_wen[i] overrides any same-cycle software write or read-clear of register i. reg <= hw_next slice i.
  - The software access still completes; for a read, read_data returns the pre-edge value.
  - sw_written[i] is suppressed when hardware wins.
- reg_q reflects register contents directly; there is no extra delay.
- A write to a W1C register with write_data=0 is effective but changes nothing; sw_written still pulses.

Decomposition:
- Package param_rf_pkg:
  - access-mode enum {RW, RO, W1C, RC}
  - function mode_of(i) deriving the mode from the masks (RO wins over W1C, W1C over RC)
  - constant WORD_SHIFT=3
- Sub-module param_rf_cell:
  - one register with its mode, hardware/software update priority and reset value
  - instantiated NUM_REGS times by a generate loop
- The top level holds address decode, the handshake registers and the read mux.

Test Plan:
- Reset then write 64'h555AAA555AAA555A to addr 0 (RW) -> next cycle access_complete=1, reg_q[0] equals the value, sw_written[0]=1.
- Same-cycle hw_wen[0]=1 with hw_next=0 and software write of 64'hFFFF to addr 0 -> reg_q[0]=0, access_complete=1, sw_written[0]=0.
- W1C_MASK=4'b0010, hardware loads 64'hF0 into reg 1, software writes 64'h30 -> reg_q[1]=64'hC0.
- RC_MASK=4'b0100, reg 2 holds 64'h1234, read addr 2 -> read_data=64'h1234, reg_q[2]=0 the same cycle; a second read returns 0.
- Read addr 4 with NUM_REGS=4, then read_en and write_en both high at addr 0 -> invalid_address=1 both times, access_complete=0, read_data=0, reg_q unchanged.
- res pulsed high asynchronously while write_en is high -> all outputs 0 immediately, registers return to RESET_VALUE, no completion pulse.
